// File: rtl/ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ram_fifo_ctrl
//   Synchronous FIFO controller in front of a 64x8 dual-port RAM.
//   Port A of the RAM is the write port and port B is the read port. Port B
//   has a 1-cycle registered read. A 2-entry output buffer hides that latency,
//   so the controller moves 1 word/cycle in and 1 word/cycle out.
//
// Ports
//   clk          in   single clock for all logic and the RAM
//   rst          in   asynchronous, active-high reset
//   s_data       in   upstream write data
//   s_valid      in   upstream data valid
//   s_ready      out  accept; low while rst is high or the RAM is full
//   m_data       out  downstream data (head of the output buffer)
//   m_valid      out  m_data valid
//   m_ready      in   downstream accepts
//   ram_we_a     out  RAM port A write enable
//   ram_addr_a   out  RAM port A address
//   ram_data_a   out  RAM port A write data
//   ram_we_b     out  RAM port B write enable (always 0)
//   ram_addr_b   out  RAM port B address
//   ram_q_b      in   RAM port B registered read data
//   level        out  words held (RAM + in-flight read + output buffer)
//   almost_full  out  only with FIFO_AFULL_EN: registered, high when the RAM
//                     occupancy is >= AFULL_THR
//
// Optional feature macro: FIFO_AFULL_EN (undefined by default).
// ---------------------------------------------------------------------------
module ram_fifo_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 6,
  parameter int AFULL_THR = 56
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_data_a,
  output logic              ram_we_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  input  logic [DATA_W-1:0] ram_q_b,
  output logic [ADDR_W:0]   level
`ifdef FIFO_AFULL_EN
  ,
  output logic              almost_full
`endif
);

  // RAM occupancy value meaning "all DEPTH entries in use".
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  // The threshold must be a reachable RAM occupancy.
  if (AFULL_THR < 1 || AFULL_THR > (1 << ADDR_W)) begin : g_bad_afull_thr
    $error("ram_fifo_ctrl: AFULL_THR out of range");
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [ADDR_W:0]   ram_cnt_q,  ram_cnt_d;
  logic [ADDR_W:0]   level_q,    level_d;
  logic              pend_q,     pend_d;
  logic [1:0]        obuf_cnt_q, obuf_cnt_d;
  logic [DATA_W-1:0] obuf0_q,    obuf0_d;
  logic [DATA_W-1:0] obuf1_q,    obuf1_d;

  logic              push;
  logic              pop;
  logic              issue;
  logic [2:0]        obuf_next_occ;

  // -------------------------------------------------------------------------
  // Handshakes
  // -------------------------------------------------------------------------
  assign s_ready = ~rst & (ram_cnt_q != DEPTH_CNT);
  assign m_valid = (obuf_cnt_q != 2'd0);
  assign m_data  = obuf0_q;
  assign level   = level_q;

  assign push = s_valid & s_ready;
  assign pop  = m_valid & m_ready;

  // Output buffer occupancy once the current pop and the in-flight read have
  // settled. A new read may only be issued if its word will have a free slot
  // on the edge after next, so this must stay below 2.
  assign obuf_next_occ = {1'b0, obuf_cnt_q} + {2'b00, pend_q} - {2'b00, pop};
  assign issue         = (ram_cnt_q != '0) & (obuf_next_occ < 3'd2);

  // -------------------------------------------------------------------------
  // RAM interface (combinational). Reads are issued only when ram_cnt > 0
  // and writes are blocked at ram_cnt = DEPTH, so the two ports never address
  // the same entry in the same cycle.
  // -------------------------------------------------------------------------
  assign ram_we_a   = push;
  assign ram_addr_a = wr_ptr_q;
  assign ram_data_a = s_data;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = rd_ptr_q;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q + ADDR_W'(push);
    rd_ptr_d   = rd_ptr_q + ADDR_W'(issue);
    ram_cnt_d  = ram_cnt_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(issue);
    level_d    = level_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    pend_d     = issue;
    obuf_cnt_d = obuf_cnt_q + {1'b0, pend_q} - {1'b0, pop};
    obuf0_d    = obuf0_q;
    obuf1_d    = obuf1_q;

    // pend_q marks that ram_q_b carries the word read on the previous edge.
    // Pop shifts the buffer first, then the returning word fills the first
    // free slot, which keeps the order intact when both happen together.
    // When the buffer empties, obuf0 keeps its value so m_data holds.
    if (pop) begin
      if (obuf_cnt_q == 2'd2) begin
        obuf0_d = obuf1_q;
      end
      if (pend_q) begin
        if (obuf_cnt_q == 2'd2) begin
          obuf1_d = ram_q_b;
        end else begin
          obuf0_d = ram_q_b;
        end
      end
    end else if (pend_q) begin
      if (obuf_cnt_q == 2'd0) begin
        obuf0_d = ram_q_b;
      end else begin
        obuf1_d = ram_q_b;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      level_q    <= '0;
      pend_q     <= 1'b0;
      obuf_cnt_q <= '0;
      obuf0_q    <= '0;
      obuf1_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      level_q    <= level_d;
      pend_q     <= pend_d;
      obuf_cnt_q <= obuf_cnt_d;
      obuf0_q    <= obuf0_d;
      obuf1_q    <= obuf1_d;
    end
  end

`ifdef FIFO_AFULL_EN
  // -------------------------------------------------------------------------
  // Almost-full flag, registered from the post-edge RAM occupancy.
  // -------------------------------------------------------------------------
  localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W+1)'(AFULL_THR);

  logic almost_full_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= (ram_cnt_d >= AFULL_LVL);
    end
  end

  assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_fifo_ctrl
//   Bench for ram_fifo_ctrl with a behavioural 64x8 RAM (registered port B).
//   A queue holds every accepted word; the head must match each popped word,
//   and its size must match the level output. Directed vectors cover reset and
//   single-word latency; sequences cover streaming, full, wrap, back-pressure
//   toggling, mid-operation reset and random traffic.
// ---------------------------------------------------------------------------
module tb_ram_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          ram_we_a;
  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_data_a;
  logic          ram_we_b;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_q_b = '0;
  logic [AW:0]   level;
`ifdef FIFO_AFULL_EN
  logic          almost_full;
`endif

  ram_fifo_ctrl #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .AFULL_THR(56)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .ram_we_a   (ram_we_a),
    .ram_addr_a (ram_addr_a),
    .ram_data_a (ram_data_a),
    .ram_we_b   (ram_we_b),
    .ram_addr_b (ram_addr_b),
    .ram_q_b    (ram_q_b),
    .level      (level)
`ifdef FIFO_AFULL_EN
    ,
    .almost_full(almost_full)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural dual-port RAM: port A write, port B registered read.
  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    ram_q_b <= mem[ram_addr_b];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Reference model: FIFO contents as a queue of accepted words.
  // -------------------------------------------------------------------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_w;
  int unsigned   wr_cnt = 0;
  int            pops = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      wr_cnt = 0;
    end else begin
      chk("level_vs_model", 32'(level), 32'(exp_q.size()));
      chk("level_max", 32'(level <= 7'd66), 32'd1);
      if (exp_q.size() < 64) chk("s_ready_room", 32'(s_ready), 32'd1);
      chk("we_b_zero", 32'(ram_we_b), 32'd0);
      chk("we_a_eq_push", 32'(ram_we_a), 32'(s_valid && s_ready));
      if (m_valid && m_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          chk("pop_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_w = exp_q.pop_front();
          chk("m_data_order", 32'(m_data), 32'(exp_w));
        end
      end
      if (s_valid && s_ready) begin
        chk("addr_a_seq", 32'(ram_addr_a), wr_cnt % 64);
        chk("data_a", 32'(ram_data_a), 32'(s_data));
        exp_q.push_back(s_data);
        wr_cnt++;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Directed per-cycle vectors
  // -------------------------------------------------------------------------
  typedef struct {
    logic          rst;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          m_ready;
    logic          e_s_ready;
    logic          e_m_valid;
    logic [DW-1:0] e_m_data;
    logic [AW:0]   e_level;
    logic          e_we_a;
    logic [AW-1:0] e_addr_a;
  } vec_t;

  vec_t vecs[13];

  task automatic drain(input string name);
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 200 && level != 0; c++) step();
    chk(name, 32'(level), 32'd0);
  endtask

  initial begin
    //            rst  sv   data   mr   srdy mv   mdata  lvl  we   addr
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 7'd0, 1'b0, 6'd0};
    vecs[1]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 7'd0, 1'b1, 6'd0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 7'd1, 1'b0, 6'd1};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 7'd1, 1'b0, 6'd1};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 7'd1, 1'b0, 6'd1};
    vecs[5]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'hA5, 7'd0, 1'b1, 6'd1};
    vecs[6]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'hA5, 7'd1, 1'b1, 6'd2};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 7'd2, 1'b0, 6'd3};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 7'd2, 1'b0, 6'd3};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3C, 7'd2, 1'b0, 6'd3};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h5A, 7'd1, 1'b0, 6'd3};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h5A, 7'd0, 1'b0, 6'd3};
    vecs[12] = '{1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 7'd0, 1'b0, 6'd0};

    step();
    for (int i = 0; i < 13; i++) begin
      rst     = vecs[i].rst;
      s_valid = vecs[i].s_valid;
      s_data  = vecs[i].s_data;
      m_ready = vecs[i].m_ready;
      #1;
      chk($sformatf("vec%0d_s_ready", i), 32'(s_ready),    32'(vecs[i].e_s_ready));
      chk($sformatf("vec%0d_m_valid", i), 32'(m_valid),    32'(vecs[i].e_m_valid));
      chk($sformatf("vec%0d_m_data", i),  32'(m_data),     32'(vecs[i].e_m_data));
      chk($sformatf("vec%0d_level", i),   32'(level),      32'(vecs[i].e_level));
      chk($sformatf("vec%0d_we_a", i),    32'(ram_we_a),   32'(vecs[i].e_we_a));
      chk($sformatf("vec%0d_addr_a", i),  32'(ram_addr_a), 32'(vecs[i].e_addr_a));
      step();
    end
    s_valid = 1'b0;
    rst     = 1'b0;
    step();

    // Continuous stream 0x00..0x3F with the sink always ready.
    begin
      int p0;
      p0 = pops;
      m_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
        s_valid = 1'b1;
        s_data  = 8'(i);
        chk("stream_s_ready", 32'(s_ready), 32'd1);
        step();
      end
      s_valid = 1'b0;
      step();
      step();
      chk("stream_tail_level", 32'(level), 32'd1);
      step();
      chk("stream_done_level", 32'(level), 32'd0);
      chk("stream_pop_count", 32'(pops - p0), 32'd64);
    end

    // Fill with the sink stalled: 64 RAM words plus 2 buffered words.
    begin
      int n;
      int p0;
      n = 0;
      m_ready = 1'b0;
      s_valid = 1'b1;
      for (int c = 0; c < 80; c++) begin
        s_data = 8'h10 + 8'(n);
        if (!s_ready) break;
        step();
        n++;
      end
      s_valid = 1'b0;
      chk("full_accept_count", 32'(n), 32'd66);
      chk("full_level", 32'(level), 32'd66);
      for (int c = 0; c < 3; c++) step();
      chk("full_hold_level", 32'(level), 32'd66);
      chk("full_hold_s_ready", 32'(s_ready), 32'd0);
      p0 = pops;
      m_ready = 1'b1;
      #1;
      chk("full_ready_before_pop", 32'(s_ready), 32'd0);
      step();
      chk("full_ready_after_pop", 32'(s_ready), 32'd1);
      chk("full_level_after_pop", 32'(level), 32'd65);
      drain("full_drain");
      chk("full_pop_count", 32'(pops - p0), 32'd66);
    end

    // Wrap: three rounds of 40 writes then 40 reads.
    for (int r = 0; r < 3; r++) begin
      m_ready = 1'b0;
      for (int i = 0; i < 40; i++) begin
        s_valid = 1'b1;
        s_data  = 8'($urandom);
        chk("wrap_s_ready", 32'(s_ready), 32'd1);
        step();
      end
      s_valid = 1'b0;
      chk("wrap_level", 32'(level), 32'd40);
      drain("wrap_drain");
    end

    // Toggle m_ready every cycle with continuous input.
    for (int c = 0; c < 200; c++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      m_ready = c[0];
      step();
    end
    drain("toggle_drain");

    // Reset with 20 words held.
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      s_data  = 8'hC0 + 8'(i);
      step();
    end
    s_valid = 1'b0;
    chk("prereset_level", 32'(level), 32'd20);
    rst = 1'b1;
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_release_s_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = 8'h77;
    m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    for (int c = 0; c < 10 && !m_valid; c++) step();
    chk("post_rst_m_valid", 32'(m_valid), 32'd1);
    chk("post_rst_m_data", 32'(m_data), 32'h77);
    step();
    chk("post_rst_level", 32'(level), 32'd0);

    // Random traffic with varying source/sink rates.
    for (int seg = 0; seg < 12; seg++) begin
      int pv;
      int pr;
      pv = int'($urandom_range(1, 4));
      pr = int'($urandom_range(0, 4));
      for (int c = 0; c < 200; c++) begin
        s_valid = (int'($urandom_range(0, 3)) < pv);
        s_data  = 8'($urandom);
        m_ready = (int'($urandom_range(0, 3)) < pr);
        step();
      end
    end
    drain("random_drain");
    step();
    chk("final_model_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
